// File: rtl/byte_word_assembler_if.sv
// Byte-in / word-out handshake bundle for byte_word_assembler.
// master = producer/consumer side, slave = the assembler itself.
interface byte_word_assembler_if;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [3:0]  load_en;
  logic [1:0]  lane_idx;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;

  modport master (
    output clear,
    output byte_in,
    output byte_valid,
    output word_ready,
    input  byte_ready,
    input  load_en,
    input  lane_idx,
    input  word_out,
    input  word_valid
  );

  modport slave (
    input  clear,
    input  byte_in,
    input  byte_valid,
    input  word_ready,
    output byte_ready,
    output load_en,
    output lane_idx,
    output word_out,
    output word_valid
  );
endinterface

// File: rtl/byte_word_assembler.sv
// Steers a stream of bytes into four lanes of a 32-bit word and hands the
// completed word off with a valid/ready handshake.
//
// state  | meaning
// S_FILL | accepting bytes; count_q = bytes already placed in this word
// S_HOLD | word complete, word_valid high, waiting for word_ready
module byte_word_assembler #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  byte_word_assembler_if.slave  bus
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] word_q,  word_d;
  logic [1:0]  lane;
  logic        accept;
  logic [3:0]  load_en;

  // Lane order is fixed at elaboration; lane 3 first when MSB_FIRST.
  always_comb begin
    if (MSB_FIRST) lane = 2'd3 - count_q;
    else           lane = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FILL;
      count_q <= 2'd0;
      word_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    accept  = 1'b0;
    load_en = 4'b0000;
    if (bus.clear) begin
      // Abort wins over both accept and handoff; any presented byte is dropped.
      state_d = S_FILL;
      count_d = 2'd0;
      word_d  = 32'd0;
    end else begin
      case (state_q)
        S_FILL: begin
          accept = bus.byte_valid & reset_n;
          if (accept) begin
            load_en                   = 4'b0001 << lane;
            word_d[{lane, 3'b000} +: 8] = bus.byte_in;
            count_d                   = count_q + 2'd1;
            if (count_q == 2'd3) state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.word_ready) begin
            state_d = S_FILL;
            count_d = 2'd0;
          end
        end
        default: begin
          state_d = S_FILL;
          count_d = 2'd0;
        end
      endcase
    end
  end

  // byte_ready is masked while reset is held so nothing looks accepted then.
  assign bus.byte_ready = reset_n & (state_q == S_FILL);
  assign bus.word_valid = (state_q == S_HOLD);
  assign bus.word_out   = word_q;
  assign bus.load_en    = load_en;
  assign bus.lane_idx   = lane;

endmodule

// File: tb/tb_byte_word_assembler.sv
// Self-checking bench: per-cycle vector table plus a scoreboard for
// backpressure, async reset and random traffic, on both lane orders.
module tb_byte_word_assembler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  byte_word_assembler_if bus0();
  byte_word_assembler_if bus1();

  byte_word_assembler #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  byte_word_assembler #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        clr;
    logic        bv;
    logic [7:0]  bin;
    logic        wr;
    logic        br;
    logic        wv;
    logic [1:0]  lane0;
    logic [3:0]  le0;
    logic [31:0] wo0;
    logic [1:0]  lane1;
    logic [3:0]  le1;
    logic [31:0] wo1;
  } vec_t;

  vec_t vecs[16];

  // scoreboard / model state
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] m_w0, m_w1;
  int          m_cnt;
  bit          m_hold;
  int          words_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic clr, input logic bv, input logic [7:0] bin, input logic wr);
    bus0.clear = clr; bus0.byte_valid = bv; bus0.byte_in = bin; bus0.word_ready = wr;
    bus1.clear = clr; bus1.byte_valid = bv; bus1.byte_in = bin; bus1.word_ready = wr;
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_hold = 1'b0;
    m_w0   = 32'd0;
    m_w1   = 32'd0;
    q0.delete();
    q1.delete();
  endtask

  // Called between edges with inputs already driven for the coming edge.
  task automatic sb_sample();
    bit was_hold;
    logic [31:0] e;
    was_hold = m_hold;
    check("byte_ready", {31'd0, bus0.byte_ready}, {31'd0, !was_hold});
    check("word_valid0", {31'd0, bus0.word_valid}, {31'd0, was_hold});
    check("word_valid1", {31'd0, bus1.word_valid}, {31'd0, was_hold});
    if (was_hold && bus0.word_ready) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_empty: handoff with no expected word, got %h", bus0.word_out);
      end else begin
        e = q0.pop_front();
        check("sb_word0", bus0.word_out, e);
        e = q1.pop_front();
        check("sb_word1", bus1.word_out, e);
      end
      words_rx++;
      m_hold = 1'b0;
    end
    if (!was_hold && bus0.byte_valid && !bus0.clear) begin
      check("load_en0", {28'd0, bus0.load_en}, 32'd1 << m_cnt);
      check("load_en1", {28'd0, bus1.load_en}, 32'd8 >> m_cnt);
      m_w0[8*m_cnt +: 8]     = bus0.byte_in;
      m_w1[8*(3-m_cnt) +: 8] = bus0.byte_in;
      if (m_cnt == 3) begin
        q0.push_back(m_w0);
        q1.push_back(m_w1);
        m_hold = 1'b1;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      check("load_en_idle0", {28'd0, bus0.load_en}, 32'd0);
      check("load_en_idle1", {28'd0, bus1.load_en}, 32'd0);
    end
  endtask

  task automatic sb_cycle(input logic bv, input logic [7:0] bin, input logic wr);
    @(negedge clk);
    drive(1'b0, bv, bin, wr);
    #1;
    sb_sample();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wv0"},  {31'd0, bus0.word_valid}, 32'd0);
    check({tag, "_wv1"},  {31'd0, bus1.word_valid}, 32'd0);
    check({tag, "_wo0"},  bus0.word_out, 32'd0);
    check({tag, "_wo1"},  bus1.word_out, 32'd0);
    check({tag, "_le0"},  {28'd0, bus0.load_en}, 32'd0);
    check({tag, "_le1"},  {28'd0, bus1.load_en}, 32'd0);
    check({tag, "_lane0"}, {30'd0, bus0.lane_idx}, 32'd0);
    check({tag, "_lane1"}, {30'd0, bus1.lane_idx}, 32'd3);
  endtask

  initial begin
    int cycles;
    bit have_byte;
    logic [7:0] cur_byte;

    //           clr  bv   bin    wr   br   wv   l0 le0      wo0            l1 le1      wo1
    vecs[0]  = '{1'b0,1'b1,8'h11,1'b1,1'b1,1'b0,2'd0,4'b0001,32'h00000000,2'd3,4'b1000,32'h00000000};
    vecs[1]  = '{1'b0,1'b1,8'h22,1'b1,1'b1,1'b0,2'd1,4'b0010,32'h00000011,2'd2,4'b0100,32'h11000000};
    vecs[2]  = '{1'b0,1'b1,8'h33,1'b1,1'b1,1'b0,2'd2,4'b0100,32'h00002211,2'd1,4'b0010,32'h11220000};
    vecs[3]  = '{1'b0,1'b1,8'h44,1'b1,1'b1,1'b0,2'd3,4'b1000,32'h00332211,2'd0,4'b0001,32'h11223300};
    vecs[4]  = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,2'd0,4'b0000,32'h44332211,2'd3,4'b0000,32'h11223344};
    vecs[5]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,2'd0,4'b0000,32'h44332211,2'd3,4'b0000,32'h11223344};
    vecs[6]  = '{1'b0,1'b1,8'h01,1'b1,1'b1,1'b0,2'd0,4'b0001,32'h44332211,2'd3,4'b1000,32'h11223344};
    vecs[7]  = '{1'b0,1'b1,8'h02,1'b1,1'b1,1'b0,2'd1,4'b0010,32'h44332201,2'd2,4'b0100,32'h01223344};
    vecs[8]  = '{1'b1,1'b1,8'h03,1'b1,1'b1,1'b0,2'd2,4'b0000,32'h44330201,2'd1,4'b0000,32'h01023344};
    vecs[9]  = '{1'b0,1'b1,8'h0A,1'b1,1'b1,1'b0,2'd0,4'b0001,32'h00000000,2'd3,4'b1000,32'h00000000};
    vecs[10] = '{1'b0,1'b1,8'h0B,1'b1,1'b1,1'b0,2'd1,4'b0010,32'h0000000A,2'd2,4'b0100,32'h0A000000};
    vecs[11] = '{1'b0,1'b1,8'h0C,1'b1,1'b1,1'b0,2'd2,4'b0100,32'h00000B0A,2'd1,4'b0010,32'h0A0B0000};
    vecs[12] = '{1'b0,1'b1,8'h0D,1'b1,1'b1,1'b0,2'd3,4'b1000,32'h000C0B0A,2'd0,4'b0001,32'h0A0B0C00};
    vecs[13] = '{1'b0,1'b1,8'hAA,1'b0,1'b0,1'b1,2'd0,4'b0000,32'h0D0C0B0A,2'd3,4'b0000,32'h0A0B0C0D};
    vecs[14] = '{1'b1,1'b0,8'h00,1'b1,1'b0,1'b1,2'd0,4'b0000,32'h0D0C0B0A,2'd3,4'b0000,32'h0A0B0C0D};
    vecs[15] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,2'd0,4'b0000,32'h00000000,2'd3,4'b0000,32'h00000000};

    drive(1'b0, 1'b0, 8'h00, 1'b0);
    words_rx = 0;
    model_reset();
    #1;
    check_reset_vals("rst_init");
    @(negedge clk);
    reset_n = 1'b1;

    // Table: per-cycle expectations sampled before each rising edge.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].clr, vecs[i].bv, vecs[i].bin, vecs[i].wr);
      #1;
      check($sformatf("v%0d_br0", i),  {31'd0, bus0.byte_ready}, {31'd0, vecs[i].br});
      check($sformatf("v%0d_br1", i),  {31'd0, bus1.byte_ready}, {31'd0, vecs[i].br});
      check($sformatf("v%0d_wv0", i),  {31'd0, bus0.word_valid}, {31'd0, vecs[i].wv});
      check($sformatf("v%0d_wv1", i),  {31'd0, bus1.word_valid}, {31'd0, vecs[i].wv});
      check($sformatf("v%0d_lane0", i), {30'd0, bus0.lane_idx}, {30'd0, vecs[i].lane0});
      check($sformatf("v%0d_lane1", i), {30'd0, bus1.lane_idx}, {30'd0, vecs[i].lane1});
      check($sformatf("v%0d_le0", i),  {28'd0, bus0.load_en}, {28'd0, vecs[i].le0});
      check($sformatf("v%0d_le1", i),  {28'd0, bus1.load_en}, {28'd0, vecs[i].le1});
      check($sformatf("v%0d_wo0", i),  bus0.word_out, vecs[i].wo0);
      check($sformatf("v%0d_wo1", i),  bus1.word_out, vecs[i].wo1);
    end

    // Backpressure: full word held while a byte waits upstream.
    sb_cycle(1'b1, 8'hEF, 1'b0);
    sb_cycle(1'b1, 8'hBE, 1'b0);
    sb_cycle(1'b1, 8'hAD, 1'b0);
    sb_cycle(1'b1, 8'hDE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sb_cycle(1'b1, 8'hAA, 1'b0);
      check("hold_wo0", bus0.word_out, 32'hDEADBEEF);
      check("hold_wo1", bus1.word_out, 32'hEFBEADDE);
      check("hold_le", {28'd0, bus0.load_en}, 32'd0);
    end
    sb_cycle(1'b1, 8'hAA, 1'b1);
    sb_cycle(1'b1, 8'hAA, 1'b0);
    check("post_hold_lane0", {30'd0, bus0.lane_idx}, 32'd0);
    check("post_hold_le0", {28'd0, bus0.load_en}, 32'd1);
    sb_cycle(1'b1, 8'h21, 1'b0);
    sb_cycle(1'b1, 8'h31, 1'b0);

    // Async reset between edges with three bytes in.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    model_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    sb_cycle(1'b1, 8'h55, 1'b0);
    sb_cycle(1'b1, 8'h66, 1'b0);
    sb_cycle(1'b1, 8'h77, 1'b0);
    sb_cycle(1'b1, 8'h88, 1'b0);
    check("rst_word0", bus0.word_out, 32'h00776655);
    sb_cycle(1'b0, 8'h00, 1'b1);
    check("rst_word_done", bus0.word_out, 32'h88776655);

    // Random gaps and backpressure; the producer holds a byte until taken.
    words_rx  = 0;
    cycles    = 0;
    have_byte = 1'b0;
    cur_byte  = 8'h00;
    while (words_rx < 100 && cycles < 5000) begin
      if (!have_byte && $urandom_range(1) == 1) begin
        have_byte = 1'b1;
        cur_byte  = 8'($urandom);
      end
      sb_cycle(have_byte, cur_byte, 1'($urandom_range(1)));
      if (have_byte && bus0.byte_ready) have_byte = 1'b0;
      cycles++;
    end
    check("rand_words", words_rx, 100);
    if (cycles >= 5000) begin
      n_cmp++; n_err++;
      $display("FAIL rand_timeout: got %0d words after %0d cycles", words_rx, cycles);
    end
    // At most the word still forming may be outstanding.
    check("sb_leftover", {31'd0, q0.size() > 1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/byte_word_assembler.md
Name: byte_word_assembler

Overview:
- Demultiplexing counterpart to the datapath byte-select muxes: accepts a stream of 8-bit bytes and steers each into one of four byte lanes.
- Presents the assembled 32-bit word with a valid/ready handshake.
- Sits between the 8-bit memory data bus and the instruction register / wide consumers. It replaces the per-byte IRWrite enable sequencing done by the controller.

Parameters:
- MSB_FIRST, 0: 0 = first byte lands in word_out[7:0] (lane 0 first); 1 = first byte lands in word_out[31:24] (lane 3 first).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort/restart of the current assembly.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  block can accept a byte this cycle.
- load_en  output  4  one-hot lane write strobe for the byte being accepted this cycle (debug/trace).
- lane_idx  output  2  index of the next lane to be written.
- word_out  output  32  assembled word.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  consumer takes the word this cycle.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset (reset_n low, asynchronous): state=FILL, count=0, word_out=0, word_valid=0. byte_ready=1 once reset is released. load_en=0. lane_idx = 0 (MSB_FIRST=0) or 3 (MSB_FIRST=1).
- Internal count: 2-bit, 0..3 = number of bytes accepted in the current word.
- lane_idx = count when MSB_FIRST=0; 3-count when MSB_FIRST=1.
- State FILL:
  - byte_ready=1, word_valid=0.
  - Accept = byte_valid & byte_ready.
  - On accept: lane[lane_idx] <= byte_in; other lanes hold; count increments.
  - Accept with count==3: count wraps to 0, next state = HOLD.
- State HOLD:
  - byte_ready=0, word_valid=1, word_out held stable.
  - On word_valid & word_ready: next state = FILL, count=0.
  - byte_valid is ignored in HOLD. No byte is consumed, and the producer must hold it.
- load_en:
  - Combinational, equal to accept ? (1 << lane_idx) : 4'b0000.
  - Never more than one bit set.
  - Zero in HOLD and during clear.
- Latency: word_valid rises on the clock edge that captures the 4th byte, i.e. visible the cycle after the 4th accept. Minimum cycle count per word is 5: 4 accepts + 1 handoff.
- Throughput: byte_ready is deasserted for the HOLD cycle(s). No byte is accepted in the same cycle as word handoff; the next byte is accepted the following cycle at the earliest.
- clear (synchronous, highest priority after reset):
  - Next state = FILL, count=0, word_valid=0.
  - word_out is zeroed.
  - Any byte presented in the same cycle is dropped: byte_ready stays 1 but load_en is forced to 0 and nothing is written.
  - clear in HOLD discards the pending word even if word_ready=1 that cycle.
- Partial words:
  - Lanes not yet written in the current word retain their previous-word values. Consumers read word_out only when word_valid=1.
  - After HOLD handoff, word_out keeps the old value until overwritten lane-by-lane.
- Reset mid-assembly: reset_n low at any point discards the partial word and forces all reset values immediately, regardless of clk.
- Stalls: gaps in byte_valid in FILL simply hold count. No timeout.

Test Plan:
- Reset then bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles, word_ready=1, MSB_FIRST=0 -> load_en sequence 0001,0010,0100,1000; word_valid=1 for exactly 1 cycle with word_out=0x44332211; byte_ready low that cycle.
- Same bytes with MSB_FIRST=1 -> lane_idx 3,2,1,0; word_out=0x11223344.
- Complete word 0xDEADBEEF, hold word_ready=0 for 5 cycles while byte_valid=1 with 0xAA -> word_valid and word_out stable, byte_ready=0, load_en=0; on word_ready=1 handoff, the next cycle accepts 0xAA into lane 0.
- Accept 2 bytes (0x01,0x02), then assert clear with byte_valid=1/0x03 -> nothing written; count=0, word_out=0. The next 4 bytes 0x0A,0x0B,0x0C,0x0D give 0x0D0C0B0A.
- Assert reset_n low asynchronously between clock edges after 3 bytes accepted -> outputs immediately take reset values. After release, 4 new bytes form a correct word with no stale lane data counted.
- Random byte_valid gaps (~50%) and word_ready backpressure over 100 words -> scoreboard matches every word, exactly one load_en bit per accept, no word lost or duplicated.
